// File: rtl/round_div_pkg.sv
// round_div_pkg -- shared types and constants for the round_div_pipe block.
//   rnd_mode_e : per-transaction rounding mode (2-bit encoding on the mode port)
//   SAT_CNT_W  : width of the optional saturation-event counter (sat_count)
package round_div_pkg;

    typedef enum logic [1:0] {
        TRUNC     = 2'd0,
        HALF_UP   = 2'd1,
        HALF_EVEN = 2'd2,
        CEIL      = 2'd3
    } rnd_mode_e;

    localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/round_div_core.sv
// round_div_core -- combinational divide-by-2**DIV_LOG2 with selectable rounding.
// Ports:
//   din  [IN_WIDTH]  unsigned dividend
//   mode [2]         rounding mode (rnd_mode_e encoding)
//   dout [OUT_WIDTH] rounded quotient, clamped to all ones on overflow
//   sat              rounding increment carried out of OUT_WIDTH bits
module round_div_core
    import round_div_pkg::*;
#(
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    logic [OUT_WIDTH:0] q;
    logic [OUT_WIDTH:0] sum;
    logic               g;
    logic               s;
    logic               inc;
    rnd_mode_e          m;

    assign q = (OUT_WIDTH+1)'(din[IN_WIDTH-1:DIV_LOG2]);
    assign g = din[DIV_LOG2-1];

    // With a divisor of 2 there are no bits below the guard bit.
    generate
        if (DIV_LOG2 == 1) begin : g_no_sticky
            assign s = 1'b0;
        end else begin : g_sticky
            assign s = |din[DIV_LOG2-2:0];
        end
    endgenerate

    always_comb begin
        m   = rnd_mode_e'(mode);
        inc = 1'b0;
        case (m)
            TRUNC:     inc = 1'b0;
            HALF_UP:   inc = g;
            HALF_EVEN: inc = g & (s | q[0]);
            CEIL:      inc = g | s;
            default:   inc = 1'b0;
        endcase
    end

    // One extra bit catches the carry produced by rounding up an all-ones quotient.
    assign sum  = q + (OUT_WIDTH+1)'(inc);
    assign sat  = sum[OUT_WIDTH];
    assign dout = sum[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];

endmodule

// File: rtl/round_div_pipe.sv
// round_div_pipe -- two-stage valid/ready pipeline computing a rounded
// quotient din / 2**DIV_LOG2 with saturation on overflow.
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   in_valid/in_ready    input handshake for din/mode
//   din [IN_WIDTH]       unsigned dividend
//   mode [2]             rounding mode: TRUNC, HALF_UP, HALF_EVEN, CEIL
//   out_valid/out_ready  output handshake for dout/sat
//   dout [OUT_WIDTH]     rounded quotient
//   sat                  result was clamped to all ones
//   sat_count [16]       only with ROUND_DIV_SAT_CNT_EN: delivered saturated
//                        results, sticks at 0xFFFF
// Stage 1 holds the raw operands, the rounding core sits between the stages,
// stage 2 holds the result.
module round_div_pipe
    import round_div_pkg::*;
#(
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
`ifdef ROUND_DIV_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0] sat_count
`endif
);

    logic                 s1_valid;
    logic [IN_WIDTH-1:0]  s1_din;
    logic [1:0]           s1_mode;
    logic                 s2_adv;
    logic [OUT_WIDTH-1:0] core_dout;
    logic                 core_sat;

    // Stage 2 can take new data when empty or being drained this cycle;
    // stage 1 moves forward under the same condition.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_din   <= '0;
            s1_mode  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_din  <= din;
                s1_mode <= mode;
            end
        end
    end

    round_div_core #(
        .DIV_LOG2  (DIV_LOG2),
        .OUT_WIDTH (OUT_WIDTH),
        .IN_WIDTH  (IN_WIDTH)
    ) u_core (
        .din  (s1_din),
        .mode (s1_mode),
        .dout (core_dout),
        .sat  (core_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                dout <= core_dout;
                sat  <= core_sat;
            end
        end
    end

`ifdef ROUND_DIV_SAT_CNT_EN
    // Counted on the delivering handshake, so a stalled result counts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat && (sat_count != {SAT_CNT_W{1'b1}})) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_round_div_pipe.sv
// tb_round_div_pipe -- directed bench for round_div_pipe (OUT_WIDTH=8, DIV_LOG2=3).
// A quotient/remainder model feeds a scoreboard queue; a negedge monitor checks
// every delivered result, output stability under stall, and the optional counter.
module tb_round_div_pipe;

    localparam int DL = 3;
    localparam int OW = 8;
    localparam int IW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] din;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] dout;
    logic          sat;
`ifdef ROUND_DIV_SAT_CNT_EN
    logic [15:0]   sat_count;
`endif

    int vectors = 0;
    int errors  = 0;
    int exp_sat_cnt = 0;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          s;
    } res_t;

    res_t          sb[$];
    logic          hold_v = 1'b0;
    logic [OW-1:0] hold_d;
    logic          hold_s;

    always #5 clk = ~clk;

    round_div_pipe #(.DIV_LOG2(DL), .OUT_WIDTH(OW), .IN_WIDTH(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat       (sat)
`ifdef ROUND_DIV_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    // Model: quotient and remainder by plain integer division.
    function automatic res_t model(input int x, input int m);
        int q, r, inc, sum;
        res_t o;
        q = x / 8;
        r = x % 8;
        case (m)
            0: inc = 0;
            1: inc = (r >= 4) ? 1 : 0;
            2: inc = (r > 4 || (r == 4 && (q % 2) == 1)) ? 1 : 0;
            default: inc = (r != 0) ? 1 : 0;
        endcase
        sum = q + inc;
        if (sum > 255) begin
            o.d = 8'hFF;
            o.s = 1'b1;
        end else begin
            o.d = sum[7:0];
            o.s = 1'b0;
        end
        return o;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: all handshakes are judged at the negedge, between drive and edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            hold_v = 1'b0;
            exp_sat_cnt = 0;
        end else begin
            if (hold_v) begin
                vectors++;
                if (!(out_valid && dout == hold_d && sat == hold_s)) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0h s=%0b expected v=1 d=%0h s=%0b",
                             out_valid, dout, sat, hold_d, hold_s);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = dout;
            hold_s = sat;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious: got d=%0h s=%0b expected no output", dout, sat);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    if (e.s) exp_sat_cnt++;
                    if (dout != e.d || sat != e.s) begin
                        errors++;
                        $display("FAIL result: got d=%0h s=%0b expected d=%0h s=%0b",
                                 dout, sat, e.d, e.s);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(int'(din), int'(mode)));
        end
    end

    task automatic push1(input logic [IW-1:0] d, input logic [1:0] m);
        int n;
        in_valid = 1'b1;
        din      = d;
        mode     = m;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = IW'($urandom);
        mode     = 2'($urandom);
    endtask

    // Single transaction with a hand-computed expected result.
    task automatic one(input string name, input logic [IW-1:0] d, input logic [1:0] m,
                       input int ed, input int es);
        int n;
        push1(d, m);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_dout"}, int'(dout), ed);
        chk({name, "_sat"}, int'(sat), es);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [IW-1:0] tbl [8];
        int acc;
        tbl = '{11'h000, 11'h00F, 11'h014, 11'h123, 11'h3FC, 11'h555, 11'h7FF, 11'h00C};

        reset     = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        mode      = '0;
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_sat", int'(sat), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Rounding modes at the exact half point, odd then even quotient.
        one("c_trunc",  11'h00C, 2'd0, 1, 0);
        one("c_hup",    11'h00C, 2'd1, 2, 0);
        one("c_heven",  11'h00C, 2'd2, 2, 0);
        one("c_ceil",   11'h00C, 2'd3, 2, 0);
        one("14_trunc", 11'h014, 2'd0, 2, 0);
        one("14_hup",   11'h014, 2'd1, 3, 0);
        one("14_heven", 11'h014, 2'd2, 2, 0);
        one("14_ceil",  11'h014, 2'd3, 3, 0);
        // Overflow boundary.
        one("7fc_hup",   11'h7FC, 2'd1, 8'hFF, 1);
        one("7fc_trunc", 11'h7FC, 2'd0, 8'hFF, 0);
        one("7f9_ceil",  11'h7F9, 2'd3, 8'hFF, 1);
        one("7f9_heven", 11'h7F9, 2'd2, 8'hFF, 0);

        // Back-to-back: out_valid must appear two negedges after the first accept
        // and stay up for exactly eight cycles.
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                din      = tbl[i];
                mode     = 2'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) chk("b2b_in_ready", int'(in_ready), 1);
            chk($sformatf("b2b_valid_%0d", i), int'(out_valid), (i >= 2 && i <= 9) ? 1 : 0);
            @(posedge clk);
            #1;
        end

        // Stall: only two transactions fit before in_ready drops.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din      = 11'h7FC - 11'(i);
            mode     = 2'd1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("stall_accepts", acc, 2);
        @(negedge clk);
        chk("stall_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("stall_drained", sb.size(), 0);

        // Reset with both stages full (a saturated result sitting in stage 2).
        out_ready = 1'b0;
        push1(11'h7FC, 2'd1);
        push1(11'h7FF, 2'd3);
        idle(1);
        @(negedge clk);
        chk("full_valid", int'(out_valid), 1);
        chk("full_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_dout", int'(dout), 0);
        chk("rst2_sat", int'(sat), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        idle(3);

        // Three saturating deliveries, the last one held under stall.
        one("sc1", 11'h7FC, 2'd1, 8'hFF, 1);
        one("sc2", 11'h7F9, 2'd3, 8'hFF, 1);
        out_ready = 1'b0;
        push1(11'h7FD, 2'd3);
        idle(4);
        out_ready = 1'b1;
        idle(3);
        chk("sc_model_count", exp_sat_cnt, 3);
`ifdef ROUND_DIV_SAT_CNT_EN
        chk("sat_count", int'(sat_count), 3);
`endif
        chk("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

endmodule
